// File: rtl/alu4_sequencer_pkg.sv
// alu4_seq_pkg: shared types and constants for the ALU program sequencer.
// Optional feature macro: SEQ_SINGLE_STEP_EN (adds the PAUSE state).
package alu4_seq_pkg;

    localparam int       INSTR_W = 7;
    localparam int       FN_MSB  = 6;
    localparam int       FN_LSB  = 4;
    localparam int       OP_MSB  = 3;
    localparam int       OP_LSB  = 0;
    localparam logic [2:0] F_HOLD = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3
`ifdef SEQ_SINGLE_STEP_EN
        , S_PAUSE = 3'd4
`endif
    } seq_state_e;

endpackage

// File: rtl/alu4_sequencer_if.sv
// alu4_sequencer_if: program-load, run-control and ALU-drive signals.
// Optional feature macro: SEQ_SINGLE_STEP_EN (adds the step input).
interface alu4_sequencer_if #(
    parameter int DEPTH = 8
);
    localparam int PTR_W = $clog2(DEPTH);

    logic             prog_we;
    logic [PTR_W-1:0] prog_addr;
    logic [6:0]       prog_data;
    logic             start;
    logic [PTR_W:0]   start_len;
    logic             start_clr;
    logic             abort;
`ifdef SEQ_SINGLE_STEP_EN
    logic             step;
`endif
    logic [2:0]       f_select;
    logic [3:0]       alu_a;
    logic             acc_en;
    logic             acc_clr;
    logic             busy;
    logic             done;
    logic [PTR_W-1:0] pc;

    modport master (
`ifdef SEQ_SINGLE_STEP_EN
        output step,
`endif
        output prog_we, prog_addr, prog_data, start, start_len, start_clr, abort,
        input  f_select, alu_a, acc_en, acc_clr, busy, done, pc
    );

    modport slave (
`ifdef SEQ_SINGLE_STEP_EN
        input  step,
`endif
        input  prog_we, prog_addr, prog_data, start, start_len, start_clr, abort,
        output f_select, alu_a, acc_en, acc_clr, busy, done, pc
    );

endinterface

// File: rtl/alu4_sequencer_prog_mem.sv
// alu4_prog_mem: DEPTH x INSTR_W program store, one sync write, one async read.
// Contents are deliberately not reset so a program survives a reset.
module alu4_prog_mem
    import alu4_seq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_waddr,
    input  logic [INSTR_W-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr,
    output logic [INSTR_W-1:0]         o_rdata
);
    logic [INSTR_W-1:0] r_mem [DEPTH];

    // Program write port.
    always_ff @(posedge clock) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alu4_sequencer.sv
// alu4_sequencer: plays a stored {function, operand} program into the ALU,
// one instruction per cycle, with accumulator clear/load strobes.
// Optional feature macro: SEQ_SINGLE_STEP_EN (PAUSE after each instruction,
// advanced by step).
module alu4_sequencer
    import alu4_seq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    alu4_sequencer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LEN_W = PTR_W + 1;

    seq_state_e         r_state, w_state_nxt;
    logic [PTR_W-1:0]   r_pc, w_pc_nxt, w_rd_addr;
    logic [LEN_W-1:0]   r_len, w_len_nxt, w_len_sat;
    logic [2:0]         r_f, w_f_nxt;
    logic [3:0]         r_a, w_a_nxt;
    logic               r_en, w_en_nxt;
    logic               r_clr, w_clr_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               w_we, w_issue, w_last;
    logic [INSTR_W-1:0] w_rdata;

    assign w_len_sat = (bus.start_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : bus.start_len;
    assign w_last    = (LEN_W'(r_pc) + LEN_W'(1)) == r_len;

    // Outputs are registered, so the memory is read at the pc about to be
    // presented: 0 when a run is launched, pc+1 while one is in flight.
    assign w_rd_addr = (r_state == S_IDLE || r_state == S_CLEAR) ? '0 : r_pc + PTR_W'(1);

    alu4_prog_mem #(.DEPTH(DEPTH)) u_mem (
        .clock   (clock),
        .i_we    (w_we),
        .i_waddr (bus.prog_addr),
        .i_wdata (bus.prog_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rdata)
    );

    // Next-state and next-output logic; w_issue launches the instruction at w_rd_addr.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_len_nxt   = r_len;
        w_f_nxt     = '0;
        w_a_nxt     = '0;
        w_en_nxt    = 1'b0;
        w_clr_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_we        = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_we = bus.prog_we && !reset;
                if (bus.start && !bus.abort) begin
                    w_len_nxt = w_len_sat;
                    w_pc_nxt  = '0;
                    if (bus.start_clr) begin
                        w_state_nxt = S_CLEAR;
                        w_clr_nxt   = 1'b1;
                        w_busy_nxt  = 1'b1;
                    end else if (w_len_sat != '0) begin
                        w_issue = 1'b1;
                    end else begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                    w_pc_nxt    = '0;
                end else if (r_len != '0) begin
                    w_issue = 1'b1;
                end else begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                    w_pc_nxt    = '0;
                end else begin
`ifdef SEQ_SINGLE_STEP_EN
                    w_state_nxt = S_PAUSE;
                    w_f_nxt     = r_f;
                    w_a_nxt     = r_a;
                    w_busy_nxt  = 1'b1;
`else
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_issue = 1'b1;
                    end
`endif
                end
            end
`ifdef SEQ_SINGLE_STEP_EN
            S_PAUSE: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                    w_pc_nxt    = '0;
                end else if (bus.step) begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_issue = 1'b1;
                    end
                end else begin
                    w_f_nxt    = r_f;
                    w_a_nxt    = r_a;
                    w_busy_nxt = 1'b1;
                end
            end
`endif
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_pc_nxt    = '0;
            end
        endcase
        if (w_issue) begin
            w_state_nxt = S_RUN;
            w_pc_nxt    = w_rd_addr;
            w_f_nxt     = w_rdata[FN_MSB:FN_LSB];
            w_a_nxt     = w_rdata[OP_MSB:OP_LSB];
            w_en_nxt    = (w_rdata[FN_MSB:FN_LSB] != F_HOLD);
            w_busy_nxt  = 1'b1;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_len   <= '0;
            r_f     <= '0;
            r_a     <= '0;
            r_en    <= 1'b0;
            r_clr   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_len   <= w_len_nxt;
            r_f     <= w_f_nxt;
            r_a     <= w_a_nxt;
            r_en    <= w_en_nxt;
            r_clr   <= w_clr_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.f_select = r_f;
    assign bus.alu_a    = r_a;
    assign bus.acc_en   = r_en;
    assign bus.acc_clr  = r_clr;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.pc       = r_pc;

endmodule

// File: tb/tb_alu4_sequencer.sv
// Directed bench for alu4_sequencer (DEPTH=8). Each cycle's outputs are
// packed as {acc_clr, acc_en, busy, done, f_select, alu_a, pc} and compared
// with hand-derived vectors.
module tb_alu4_sequencer;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    alu4_sequencer_if #(.DEPTH(8)) bus ();

    alu4_sequencer #(.DEPTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [13:0] obs();
        return {bus.acc_clr, bus.acc_en, bus.busy, bus.done, bus.f_select, bus.alu_a, bus.pc};
    endfunction

    function automatic logic [13:0] ex(input logic clr, input logic en, input logic bsy,
                                       input logic dn, input logic [2:0] f,
                                       input logic [3:0] a, input logic [2:0] p);
        return {clr, en, bsy, dn, f, a, p};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_prog(input logic [2:0] addr, input logic [6:0] data);
        bus.prog_we   = 1'b1;
        bus.prog_addr = addr;
        bus.prog_data = data;
        tick();
        bus.prog_we   = 1'b0;
    endtask

    // Drives start for one edge; on return the bench is looking at cycle 1.
    task automatic do_start(input logic [3:0] len, input logic clr);
        bus.start     = 1'b1;
        bus.start_len = len;
        bus.start_clr = clr;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.start_len = 4'd3;
        tick();
        tick();
        bus.start = 1'b0;
        checks++;
        if (obs() !== 14'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", obs(), 14'h0);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (obs() !== 14'h0) begin
            failures++;
            $display("FAIL post_reset_idle got=%h exp=%h", obs(), 14'h0);
        end
    endtask

    task automatic test_basic();
        logic [13:0] exp_t [1:5];
        logic [7:0]  acc;
        write_prog(3'd0, 7'b001_0011);
        write_prog(3'd1, 7'b001_0101);
        write_prog(3'd2, 7'b111_0000);
        exp_t[1] = ex(1, 0, 1, 0, 3'd0, 4'd0, 3'd0);
        exp_t[2] = ex(0, 1, 1, 0, 3'd1, 4'd3, 3'd0);
        exp_t[3] = ex(0, 1, 1, 0, 3'd1, 4'd5, 3'd1);
        exp_t[4] = ex(0, 0, 1, 0, 3'd7, 4'd0, 3'd2);
        exp_t[5] = ex(0, 0, 0, 1, 3'd0, 4'd0, 3'd2);
        acc = 8'hAA;
        do_start(4'd3, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if (obs() !== exp_t[c]) begin
                failures++;
                $display("FAIL basic cyc=%0d got=%h exp=%h", c, obs(), exp_t[c]);
            end
            if (bus.acc_clr) acc = 8'h00;
            else if (bus.acc_en && bus.f_select == 3'b001) acc = acc + {4'h0, bus.alu_a};
            tick();
        end
        checks++;
        if (acc !== 8'h08) begin
            failures++;
            $display("FAIL basic_acc got=%h exp=%h", acc, 8'h08);
        end
    endtask

    task automatic test_len0();
        do_start(4'd0, 1'b0);
        checks++;
        if (obs() !== ex(0, 0, 0, 1, 3'd0, 4'd0, 3'd0)) begin
            failures++;
            $display("FAIL len0_done got=%h exp=%h", obs(), ex(0, 0, 0, 1, 3'd0, 4'd0, 3'd0));
        end
        for (int c = 2; c <= 4; c++) begin
            tick();
            checks++;
            if (obs() !== 14'h0) begin
                failures++;
                $display("FAIL len0_quiet cyc=%0d got=%h exp=%h", c, obs(), 14'h0);
            end
        end
        do_start(4'd0, 1'b1);
        checks++;
        if (obs() !== ex(1, 0, 1, 0, 3'd0, 4'd0, 3'd0)) begin
            failures++;
            $display("FAIL len0_clr_c1 got=%h exp=%h", obs(), ex(1, 0, 1, 0, 3'd0, 4'd0, 3'd0));
        end
        tick();
        checks++;
        if (obs() !== ex(0, 0, 0, 1, 3'd0, 4'd0, 3'd0)) begin
            failures++;
            $display("FAIL len0_clr_c2 got=%h exp=%h", obs(), ex(0, 0, 0, 1, 3'd0, 4'd0, 3'd0));
        end
        tick();
    endtask

    task automatic test_abort();
        write_prog(3'd0, 7'b001_0001);
        write_prog(3'd1, 7'b001_0010);
        write_prog(3'd2, 7'b001_0100);
        write_prog(3'd3, 7'b001_1000);
        do_start(4'd4, 1'b0);
        checks++;
        if (obs() !== ex(0, 1, 1, 0, 3'd1, 4'd1, 3'd0)) begin
            failures++;
            $display("FAIL abort_c1 got=%h exp=%h", obs(), ex(0, 1, 1, 0, 3'd1, 4'd1, 3'd0));
        end
        tick();
        bus.abort = 1'b1;
        checks++;
        if (obs() !== ex(0, 1, 1, 0, 3'd1, 4'd2, 3'd1)) begin
            failures++;
            $display("FAIL abort_c2 got=%h exp=%h", obs(), ex(0, 1, 1, 0, 3'd1, 4'd2, 3'd1));
        end
        tick();
        bus.abort = 1'b0;
        checks++;
        if (obs() !== 14'h0) begin
            failures++;
            $display("FAIL abort_c3 got=%h exp=%h", obs(), 14'h0);
        end
        for (int c = 4; c <= 7; c++) begin
            tick();
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL abort_no_done cyc=%0d got=%b%b exp=00", c, bus.done, bus.busy);
            end
        end
        do_start(4'd1, 1'b0);
        checks++;
        if (obs() !== ex(0, 1, 1, 0, 3'd1, 4'd1, 3'd0)) begin
            failures++;
            $display("FAIL abort_restart got=%h exp=%h", obs(), ex(0, 1, 1, 0, 3'd1, 4'd1, 3'd0));
        end
        tick();
        checks++;
        if (obs() !== ex(0, 0, 0, 1, 3'd0, 4'd0, 3'd0)) begin
            failures++;
            $display("FAIL abort_restart_done got=%h exp=%h", obs(), ex(0, 0, 0, 1, 3'd0, 4'd0, 3'd0));
        end
        tick();
    endtask

    task automatic test_busy_ignore();
        logic [13:0] exp_t [2:5];
        exp_t[2] = ex(0, 1, 1, 0, 3'd1, 4'd2, 3'd1);
        exp_t[3] = ex(0, 1, 1, 0, 3'd1, 4'd4, 3'd2);
        exp_t[4] = ex(0, 1, 1, 0, 3'd1, 4'd8, 3'd3);
        exp_t[5] = ex(0, 0, 0, 1, 3'd0, 4'd0, 3'd3);
        do_start(4'd4, 1'b0);
        bus.prog_we   = 1'b1;
        bus.prog_addr = 3'd0;
        bus.prog_data = 7'b010_1111;
        bus.start     = 1'b1;
        bus.start_len = 4'd1;
        bus.start_clr = 1'b1;
        tick();
        bus.prog_we = 1'b0;
        bus.start   = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            checks++;
            if (obs() !== exp_t[c]) begin
                failures++;
                $display("FAIL busy_ignore cyc=%0d got=%h exp=%h", c, obs(), exp_t[c]);
            end
            tick();
        end
        do_start(4'd1, 1'b0);
        checks++;
        if (obs() !== ex(0, 1, 1, 0, 3'd1, 4'd1, 3'd0)) begin
            failures++;
            $display("FAIL busy_readback got=%h exp=%h", obs(), ex(0, 1, 1, 0, 3'd1, 4'd1, 3'd0));
        end
        tick();
        tick();
    endtask

    task automatic test_saturate();
        int en_cnt;
        for (int i = 0; i < 8; i++) write_prog(3'(i), {3'b001, 4'(i)});
        en_cnt = 0;
        do_start(4'd9, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (obs() !== ex(0, 1, 1, 0, 3'd1, 4'(c - 1), 3'(c - 1))) begin
                failures++;
                $display("FAIL sat_issue cyc=%0d got=%h exp=%h", c, obs(),
                         ex(0, 1, 1, 0, 3'd1, 4'(c - 1), 3'(c - 1)));
            end
            if (bus.acc_en) en_cnt++;
            tick();
        end
        checks++;
        if (obs() !== ex(0, 0, 0, 1, 3'd0, 4'd0, 3'd7)) begin
            failures++;
            $display("FAIL sat_done got=%h exp=%h", obs(), ex(0, 0, 0, 1, 3'd0, 4'd0, 3'd7));
        end
        checks++;
        if (en_cnt !== 8) begin
            failures++;
            $display("FAIL sat_count got=%0d exp=8", en_cnt);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        do_start(4'd2, 1'b0);
        tick();
        checks++;
        if (obs() !== ex(0, 1, 1, 0, 3'd1, 4'd1, 3'd1)) begin
            failures++;
            $display("FAIL b2b_c2 got=%h exp=%h", obs(), ex(0, 1, 1, 0, 3'd1, 4'd1, 3'd1));
        end
        tick();
        checks++;
        if (obs() !== ex(0, 0, 0, 1, 3'd0, 4'd0, 3'd1)) begin
            failures++;
            $display("FAIL b2b_done got=%h exp=%h", obs(), ex(0, 0, 0, 1, 3'd0, 4'd0, 3'd1));
        end
        bus.start     = 1'b1;
        bus.start_len = 4'd1;
        bus.start_clr = 1'b0;
        tick();
        checks++;
        if (obs() !== ex(0, 0, 0, 0, 3'd0, 4'd0, 3'd1)) begin
            failures++;
            $display("FAIL b2b_idle got=%h exp=%h", obs(), ex(0, 0, 0, 0, 3'd0, 4'd0, 3'd1));
        end
        tick();
        bus.start = 1'b0;
        checks++;
        if (obs() !== ex(0, 1, 1, 0, 3'd1, 4'd0, 3'd0)) begin
            failures++;
            $display("FAIL b2b_issue got=%h exp=%h", obs(), ex(0, 1, 1, 0, 3'd1, 4'd0, 3'd0));
        end
        tick();
        checks++;
        if (obs() !== ex(0, 0, 0, 1, 3'd0, 4'd0, 3'd0)) begin
            failures++;
            $display("FAIL b2b_done2 got=%h exp=%h", obs(), ex(0, 0, 0, 1, 3'd0, 4'd0, 3'd0));
        end
        tick();
    endtask

    task automatic test_mid_reset();
        do_start(4'd5, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (obs() !== 14'h0) begin
            failures++;
            $display("FAIL mid_reset got=%h exp=%h", obs(), 14'h0);
        end
        tick();
    endtask

`ifdef SEQ_SINGLE_STEP_EN
    task automatic test_step();
        logic [13:0] exp_t [1:6];
        write_prog(3'd0, 7'b001_0001);
        write_prog(3'd1, 7'b001_0010);
        exp_t[1] = ex(0, 1, 1, 0, 3'd1, 4'd1, 3'd0);
        exp_t[2] = ex(0, 0, 1, 0, 3'd1, 4'd1, 3'd0);
        exp_t[3] = ex(0, 0, 1, 0, 3'd1, 4'd1, 3'd0);
        exp_t[4] = ex(0, 1, 1, 0, 3'd1, 4'd2, 3'd1);
        exp_t[5] = ex(0, 0, 1, 0, 3'd1, 4'd2, 3'd1);
        exp_t[6] = ex(0, 0, 0, 1, 3'd0, 4'd0, 3'd1);
        do_start(4'd2, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if (obs() !== exp_t[c]) begin
                failures++;
                $display("FAIL step cyc=%0d got=%h exp=%h", c, obs(), exp_t[c]);
            end
            bus.step = (c == 3 || c == 5);
            tick();
        end
        bus.step = 1'b0;
    endtask
`endif

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.start     = 1'b0;
        bus.start_len = '0;
        bus.start_clr = 1'b0;
        bus.abort     = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        bus.step      = 1'b0;
`endif
        test_reset();
`ifdef SEQ_SINGLE_STEP_EN
        test_step();
`else
        test_basic();
        test_len0();
        test_abort();
        test_busy_ignore();
        test_saturate();
        test_back_to_back();
`endif
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
